modexp: RTL and testbench

Iterative modular exponentiation engine computing res = a^b mod p on WIDTH-bit unsigned operands. It is the responder side of the start/valid compute interface that the simulation benches drive: a one-cycle start launches a job, a one-cycle valid returns the result. Arithmetic is a left-to-right square-and-multiply built on a bit-serial interleaved modular multiplier, so no wide multiplier is needed.

---
 rtl/modexp_pkg.sv | 16 +
 rtl/modexp_modmul.sv | 76 +++++++
 rtl/modexp.sv | 177 +++++++++++++++++
 tb/tb_modexp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular exponentiation engine.
package modexp_pkg;

    localparam int unsigned DEF_WIDTH = 128;

    localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        SQR    = 3'd2,
        MUL    = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/modexp_modmul.sv
// Bit-serial interleaved modular multiplier: acc = x*y mod p in WIDTH cycles,
// scanning y MSB first. The first step is taken on the edge that samples go.
module modmul
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] acc,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic [WIDTH-1:0] step_c;

    // One interleaved step: double, reduce, conditionally add x, reduce.
    function automatic logic [WIDTH-1:0] mm_step(
        input logic [WIDTH-1:0] acc_i,
        input logic [WIDTH-1:0] x_i,
        input logic [WIDTH-1:0] p_i,
        input logic             bit_i
    );
        logic [WIDTH:0] t;
        t = {acc_i, 1'b0};
        if (t >= {1'b0, p_i}) t = t - {1'b0, p_i};
        if (bit_i)            t = t + {1'b0, x_i};
        if (t >= {1'b0, p_i}) t = t - {1'b0, p_i};
        return WIDTH'(t);
    endfunction

    // On go the accumulator is treated as zero and operands come straight from the ports.
    always_comb begin
        step_c = '0;
        if (go) step_c = mm_step('0, x, p, y[WIDTH-1]);
        else    step_c = mm_step(acc, x_q, p, y_q[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            x_q  <= '0;
            y_q  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                acc  <= step_c;
                x_q  <= x;
                y_q  <= {y[WIDTH-2:0], 1'b0};
                cnt  <= CNT_W'(WIDTH - 1);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= step_c;
                y_q <= {y_q[WIDTH-2:0], 1'b0};
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/modexp.sv
// Left-to-right square-and-multiply modular exponentiation, res = a^b mod p,
// sequencing one modmul back-to-back through REDUCE, SQR and MUL.
module modexp
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] res,
    output logic             valid
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

    state_e state, state_nxt;

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] r;
    logic [IDX_W-1:0] idx;

    logic             go_c;
    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] y_c;
    logic [WIDTH-1:0] p_c;
    logic             accept_c;
    logic             load_base_c;
    logic             load_r_c;
    logic             dec_idx_c;
    logic             finish_c;
    logic             zero_done_c;

    logic [WIDTH-1:0] mm_acc;
    logic             mm_done;

    // The modulus is taken from the port on the accepting edge, afterwards from the latch.
    assign p_c = (state == IDLE) ? p : p_q;

    modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go_c),
        .x     (x_c),
        .y     (y_c),
        .p     (p_c),
        .acc   (mm_acc),
        .done  (mm_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = (p > ONE_W) ? REDUCE : DONE;
            REDUCE:  if (mm_done) state_nxt = SQR;
            SQR: begin
                if (mm_done) begin
                    if (b_q[idx])               state_nxt = MUL;
                    else if (idx == IDX_W'(0))  state_nxt = DONE;
                    else                        state_nxt = SQR;
                end
            end
            MUL:     if (mm_done) state_nxt = (idx == IDX_W'(0)) ? DONE : SQR;
            // A degenerate job enters with valid low and spends one extra cycle raising it.
            DONE:    state_nxt = valid ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        go_c        = 1'b0;
        x_c         = '0;
        y_c         = '0;
        accept_c    = 1'b0;
        load_base_c = 1'b0;
        load_r_c    = 1'b0;
        dec_idx_c   = 1'b0;
        finish_c    = 1'b0;
        zero_done_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (p > ONE_W) begin
                        go_c = 1'b1;
                        x_c  = ONE_W;
                        y_c  = a;
                    end
                end
            end
            REDUCE: begin
                if (mm_done) begin
                    load_base_c = 1'b1;
                    go_c        = 1'b1;
                    x_c         = r;
                    y_c         = r;
                end
            end
            SQR: begin
                if (mm_done) begin
                    load_r_c = 1'b1;
                    if (b_q[idx]) begin
                        go_c = 1'b1;
                        x_c  = base;
                        y_c  = mm_acc;
                    end else if (idx != IDX_W'(0)) begin
                        dec_idx_c = 1'b1;
                        go_c      = 1'b1;
                        x_c       = mm_acc;
                        y_c       = mm_acc;
                    end else begin
                        finish_c = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mm_done) begin
                    load_r_c = 1'b1;
                    if (idx != IDX_W'(0)) begin
                        dec_idx_c = 1'b1;
                        go_c      = 1'b1;
                        x_c       = mm_acc;
                        y_c       = mm_acc;
                    end else begin
                        finish_c = 1'b1;
                    end
                end
            end
            DONE:    zero_done_c = !valid;
            default: ;
        endcase
    end

    // Datapath registers; r starts at 1, or 0 for a degenerate modulus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q   <= '0;
            p_q   <= '0;
            base  <= '0;
            r     <= '0;
            idx   <= '0;
            res   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept_c) begin
                b_q <= b;
                p_q <= p;
                idx <= IDX_W'(WIDTH - 1);
                r   <= (p > ONE_W) ? ONE_W : '0;
            end
            if (load_base_c) base <= mm_acc;
            if (load_r_c)    r    <= mm_acc;
            if (dec_idx_c)   idx  <= idx - IDX_W'(1);
            if (finish_c) begin
                res   <= mm_acc;
                valid <= 1'b1;
            end
            if (zero_done_c) begin
                res   <= r;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modexp.sv
// Self-checking bench for modexp at WIDTH 8, 16 and 128.
module tb_modexp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         s8 = 1'b0, s16 = 1'b0, s128 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0, p8 = '0, r8;
    logic [15:0]  a16 = '0, b16 = '0, p16 = '0, r16;
    logic [127:0] a128 = '0, b128 = '0, p128 = '0, r128;
    logic         v8, v16, v128;

    modexp #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .p(p8), .res(r8), .valid(v8));
    modexp #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .p(p16), .res(r16), .valid(v16));
    modexp #(.WIDTH(128)) u128 (
        .clk(clk), .rst_n(rst_n), .start(s128), .a(a128), .b(b128), .p(p128), .res(r128), .valid(v128));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] res;
        int         lat;
    } vec8_t;

    vec8_t tv[9];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] p);
        case (w)
            8:  begin s8 = st;   a8 = a[7:0];   b8 = b[7:0];   p8 = p[7:0];   end
            16: begin s16 = st;  a16 = a[15:0]; b16 = b[15:0]; p16 = p[15:0]; end
            default: begin s128 = st; a128 = a; b128 = b; p128 = p; end
        endcase
    endtask

    function automatic logic get_valid(input int w);
        case (w)
            8:       return v8;
            16:      return v16;
            default: return v128;
        endcase
    endfunction

    function automatic logic [127:0] get_res(input int w);
        case (w)
            8:       return {120'd0, r8};
            16:      return {112'd0, r16};
            default: return r128;
        endcase
    endfunction

    // Presents start for exactly one cycle; returns #1 after edge 0.
    task automatic launch(input int w, input logic [127:0] a, input logic [127:0] b,
                          input logic [127:0] p);
        @(negedge clk);
        drive(w, 1'b1, a, b, p);
        @(posedge clk);
        #1;
        drive(w, 1'b0, a, b, p);
    endtask

    // Waits for valid, reports edge number and result, then checks valid drops next edge.
    task automatic job(input int w, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] p, output logic [127:0] r, output int lat);
        launch(w, a, b, p);
        lat = -1;
        r   = '0;
        for (int n = 1; n <= 40000; n++) begin
            @(posedge clk);
            #1;
            if (get_valid(w)) begin
                lat = n;
                r   = get_res(w);
                break;
            end
        end
        @(posedge clk);
        #1;
        check("valid_one_cycle", {127'd0, get_valid(w)}, 128'd0);
    endtask

    function automatic longint unsigned ref_modexp(input longint unsigned a, input longint unsigned b,
                                                   input longint unsigned p);
        longint unsigned rr, bs;
        rr = 1;
        bs = a % p;
        for (int i = 15; i >= 0; i--) begin
            rr = (rr * rr) % p;
            if (b[i]) rr = (rr * bs) % p;
        end
        return rr;
    endfunction

    logic [127:0] got;
    logic [127:0] big_p;
    int           lat;
    int           vcnt;
    int           first_lat;
    logic [127:0] first_res;

    initial begin
        tv[0] = '{a: 8'd25,  b: 8'd23,  p: 8'd18,  res: 8'd13,  lat: 104};
        tv[1] = '{a: 8'd77,  b: 8'd0,   p: 8'd18,  res: 8'd1,   lat: 72};
        tv[2] = '{a: 8'd77,  b: 8'd0,   p: 8'd1,   res: 8'd0,   lat: 1};
        tv[3] = '{a: 8'd77,  b: 8'd0,   p: 8'd0,   res: 8'd0,   lat: 1};
        tv[4] = '{a: 8'd3,   b: 8'd4,   p: 8'd7,   res: 8'd4,   lat: 80};
        tv[5] = '{a: 8'd255, b: 8'd1,   p: 8'd254, res: 8'd1,   lat: 80};
        tv[6] = '{a: 8'd10,  b: 8'd3,   p: 8'd13,  res: 8'd12,  lat: 88};
        tv[7] = '{a: 8'd2,   b: 8'd8,   p: 8'd200, res: 8'd56,  lat: 80};
        tv[8] = '{a: 8'd200, b: 8'd2,   p: 8'd255, res: 8'd220, lat: 80};

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid8", {127'd0, v8}, 128'd0);
        check("reset_res8", {120'd0, r8}, 128'd0);
        check("reset_res128", r128, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 8-bit table.
        for (int i = 0; i < 9; i++) begin
            job(8, {120'd0, tv[i].a}, {120'd0, tv[i].b}, {120'd0, tv[i].p}, got, lat);
            check($sformatf("vec%0d_res", i), got, {120'd0, tv[i].res});
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'(tv[i].lat));
        end

        // 128-bit Mersenne modulus.
        big_p = {1'b0, {127{1'b1}}};
        job(128, 128'd2, 128'd127, big_p, got, lat);
        check("w128_pow2_res", got, 128'd1);
        check("w128_pow2_lat", 128'(lat), 128'(136 * 128));
        job(128, big_p - 128'd1, 128'd2, big_p, got, lat);
        check("w128_neg1_res", got, 128'd1);
        check("w128_neg1_lat", 128'(lat), 128'(130 * 128));

        // start held high through the job: one result only.
        @(negedge clk);
        drive(8, 1'b1, 128'd25, 128'd23, 128'd18);
        @(posedge clk);
        #1;
        vcnt = 0; first_lat = -1; first_res = '0;
        for (int n = 1; n <= 130; n++) begin
            @(posedge clk);
            #1;
            if (v8) begin
                vcnt++;
                if (first_lat < 0) begin first_lat = n; first_res = {120'd0, r8}; end
                drive(8, 1'b0, 128'd25, 128'd23, 128'd18);
            end
        end
        check("held_start_count", 128'(vcnt), 128'd1);
        check("held_start_lat", 128'(first_lat), 128'd104);
        check("held_start_res", first_res, 128'd13);

        // start re-pulsed mid-job with different operands: ignored.
        launch(8, 128'd25, 128'd23, 128'd18);
        vcnt = 0; first_lat = -1; first_res = '0;
        for (int n = 1; n <= 130; n++) begin
            @(posedge clk);
            #1;
            if (v8) begin
                vcnt++;
                if (first_lat < 0) begin first_lat = n; first_res = {120'd0, r8}; end
            end
            if (n == 10 || n == 50) drive(8, 1'b1, 128'd99, 128'd5, 128'd7);
            else                    drive(8, 1'b0, 128'd99, 128'd5, 128'd7);
        end
        check("repulse_count", 128'(vcnt), 128'd1);
        check("repulse_lat", 128'(first_lat), 128'd104);
        check("repulse_res", first_res, 128'd13);

        // Back-to-back: start raised in the IDLE cycle right after DONE.
        job(8, 128'd25, 128'd23, 128'd18, got, lat);
        job(8, 128'd10, 128'd3, 128'd13, got, lat);
        check("b2b_res", got, 128'd12);
        check("b2b_lat", 128'(lat), 128'd88);

        // Reset during REDUCE (res is 12 beforehand).
        launch(8, 128'd25, 128'd23, 128'd18);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_reduce_valid", {127'd0, v8}, 128'd0);
        check("rst_reduce_res", {120'd0, r8}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 150; n++) begin
            @(posedge clk);
            #1;
            if (v8) vcnt++;
        end
        check("rst_reduce_no_valid", 128'(vcnt), 128'd0);

        // Reset during the first MUL (edges 40..47 for b=23).
        job(8, 128'd3, 128'd4, 128'd7, got, lat);
        check("pre_rst_res", got, 128'd4);
        launch(8, 128'd25, 128'd23, 128'd18);
        repeat (43) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mul_valid", {127'd0, v8}, 128'd0);
        check("rst_mul_res", {120'd0, r8}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 150; n++) begin
            @(posedge clk);
            #1;
            if (v8) vcnt++;
        end
        check("rst_mul_no_valid", 128'(vcnt), 128'd0);
        job(8, 128'd25, 128'd23, 128'd18, got, lat);
        check("post_rst_res", got, 128'd13);
        check("post_rst_lat", 128'(lat), 128'd104);

        // Random 16-bit jobs against the reference model.
        for (int k = 0; k < 10; k++) begin
            logic [15:0] ra, rb, rp;
            longint unsigned exp_r;
            int exp_lat;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rp = 16'($urandom_range(65535, 2));
            exp_r = ref_modexp(64'(ra), 64'(rb), 64'(rp));
            exp_lat = (17 + $countones(rb)) * 16;
            job(16, {112'd0, ra}, {112'd0, rb}, {112'd0, rp}, got, lat);
            check($sformatf("rand%0d_res", k), got, 128'(exp_r));
            check($sformatf("rand%0d_lat", k), 128'(lat), 128'(exp_lat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
